// File: rtl/wb_arbiter.sv
// wb_arbiter: merges NUM_CH writeback sources into one registered
// register-file write port. Each channel owns a DEPTH-entry FIFO with
// ready/valid push and a per-channel flush; a round-robin arbiter pops at
// most one head per cycle into the output register and pulses wb_retire.
// Optional macro WB_RETIRE_CNT_EN builds a 64-bit retired-entry counter;
// without it wb_retire_cnt is tied to zero.
module wb_arbiter #(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 2,
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic [NUM_CH-1:0]        ch_flush,
  input  logic [NUM_CH-1:0]        ch_rd_write,
  input  logic [NUM_CH*REG_AW-1:0] ch_rd_addr,
  input  logic [NUM_CH*XLEN-1:0]   ch_rd_data,
  output logic                     wb_rd_write,
  output logic [REG_AW-1:0]        wb_rd_addr,
  output logic [XLEN-1:0]          wb_rd_wdata,
  output logic                     wb_retire,
  output logic [CH_W-1:0]          wb_retire_ch,
  output logic                     wb_busy,
  output logic [63:0]              wb_retire_cnt
);

  localparam int PW = $clog2(DEPTH);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PW:0]        wr_ptr    [NUM_CH];
  logic [PW:0]        rd_ptr    [NUM_CH];
  logic [XLEN-1:0]    fifo_data [NUM_CH][DEPTH];
  logic [REG_AW-1:0]  fifo_addr [NUM_CH][DEPTH];
  logic               fifo_wr   [NUM_CH][DEPTH];

  logic [NUM_CH-1:0]  empty;
  logic [NUM_CH-1:0]  full;
  logic [NUM_CH-1:0]  push;
  logic [NUM_CH-1:0]  req;

  logic [CH_W-1:0]    last_gnt;
  logic               gnt_vld_p0;
  logic [CH_W-1:0]    gnt_idx_p0;
  logic               head_wr_p0;
  logic [REG_AW-1:0]  head_addr_p0;
  logic [XLEN-1:0]    head_data_p0;

  // FIFO status per channel; ready depends only on state and flush.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][PW] != rd_ptr[i][PW]) &&
                 (wr_ptr[i][PW-1:0] == rd_ptr[i][PW-1:0]);
    end
  end

  assign ch_ready = ~full & ~ch_flush;
  assign push     = ch_valid & ch_ready;
  assign req      = ~empty & ~ch_flush;
  assign wb_busy  = |(~empty);

  // Round-robin: first requesting channel strictly after the last grant.
  always_comb begin
    logic [CH_W-1:0] cand;
    cand       = '0;
    gnt_vld_p0 = 1'b0;
    gnt_idx_p0 = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(last_gnt) + k) % NUM_CH);
      if (!gnt_vld_p0 && req[cand]) begin
        gnt_vld_p0 = 1'b1;
        gnt_idx_p0 = cand;
      end
    end
  end

  // Head entry of the granted channel.
  always_comb begin
    head_wr_p0   = fifo_wr[gnt_idx_p0][rd_ptr[gnt_idx_p0][PW-1:0]];
    head_addr_p0 = fifo_addr[gnt_idx_p0][rd_ptr[gnt_idx_p0][PW-1:0]];
    head_data_p0 = fifo_data[gnt_idx_p0][rd_ptr[gnt_idx_p0][PW-1:0]];
  end

  // FIFO pointers: flush empties the queue, otherwise push and pop advance.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_flush[i]) begin
          rd_ptr[i] <= wr_ptr[i];
        end else begin
          if (push[i])
            wr_ptr[i] <= wr_ptr[i] + 1'b1;
          if (gnt_vld_p0 && (gnt_idx_p0 == CH_W'(i)))
            rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
      end
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        fifo_wr[i][wr_ptr[i][PW-1:0]]   <= ch_rd_write[i];
        fifo_addr[i][wr_ptr[i][PW-1:0]] <= ch_rd_addr[i*REG_AW +: REG_AW];
        fifo_data[i][wr_ptr[i][PW-1:0]] <= ch_rd_data[i*XLEN +: XLEN];
      end
    end
  end

  // ---- stage p1: registered write port, retire pulse, grant pointer ----
  // Writes to x0 still retire but never assert the write enable.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wb_rd_write  <= 1'b0;
      wb_rd_addr   <= '0;
      wb_rd_wdata  <= '0;
      wb_retire    <= 1'b0;
      wb_retire_ch <= '0;
      last_gnt     <= CH_W'(NUM_CH - 1);
    end else if (gnt_vld_p0) begin
      wb_rd_write  <= head_wr_p0 & (head_addr_p0 != '0);
      wb_rd_addr   <= head_addr_p0;
      wb_rd_wdata  <= head_data_p0;
      wb_retire    <= 1'b1;
      wb_retire_ch <= gnt_idx_p0;
      last_gnt     <= gnt_idx_p0;
    end else begin
      wb_rd_write  <= 1'b0;
      wb_retire    <= 1'b0;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_p1;

  // Counts every pop, wrapping naturally at 2^64.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      retire_cnt_p1 <= '0;
    else if (gnt_vld_p0)
      retire_cnt_p1 <= retire_cnt_p1 + 64'd1;
  end

  assign wb_retire_cnt = retire_cnt_p1;
`else
  assign wb_retire_cnt = 64'd0;
`endif

endmodule
